// File: rtl/sram_axi4_pkg.sv
// Shared types for the AXI4 burst SRAM slave: burst encodings, response codes, FSM states.
// Used by sram_axi4_burst (optional SRAM_AXI4_REG_OUT_EN build) and sram_axi4_addr_gen.
package sram_axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/sram_axi4_addr_gen.sv
// Next word address for one burst beat plus an illegal-burst flag.
// Pure combinational; one instance serves each channel.
module sram_axi4_addr_gen
    import sram_axi4_pkg::*;
#(
    parameter int WORD_AW = 9
) (
    input  logic [WORD_AW-1:0] i_addr,
    input  logic [7:0]         i_len,
    input  logic [1:0]         i_burst,
    output logic [WORD_AW-1:0] o_next_addr,
    output logic               o_burst_err
);

    logic [WORD_AW-1:0] w_incr;
    logic [WORD_AW-1:0] w_mask;

    assign w_incr = i_addr + WORD_AW'(1);
    // For a legal WRAP, len+1 is a power of two so len itself is the in-window offset mask.
    assign w_mask = WORD_AW'(i_len);

    always_comb begin
        o_next_addr = i_addr;
        o_burst_err = 1'b0;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = w_incr;
            BURST_WRAP: begin
                o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
                o_burst_err = !wrap_len_ok(i_len);
            end
            default: begin
                o_next_addr = i_addr;
                o_burst_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sram_axi4_burst.sv
// AXI4 burst slave in front of a word-wide SRAM, independent read and write channels.
// Define SRAM_AXI4_REG_OUT_EN to register rdata/rresp/rlast (2-cycle first-beat latency).
module sram_axi4_burst
    import sram_axi4_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12,
    parameter int ID_W   = 4
) (
    input  logic                i_aclk,
    input  logic                i_areset,
    input  logic [ID_W-1:0]     i_arid,
    input  logic [ADDR_W-1:0]   i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [ID_W-1:0]     o_rid,
    output logic [DATA_W-1:0]   o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready,
    input  logic [ID_W-1:0]     i_awid,
    input  logic [ADDR_W-1:0]   i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_W-1:0]     o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int BYTE_AW = $clog2(STRB_W);
    localparam int WORD_AW = ADDR_W - BYTE_AW;
    localparam int DEPTH   = 1 << WORD_AW;

    // Handshake rule on every channel: a transfer happens on a rising edge where valid && ready;
    // a source holds valid and its payload unchanged until that edge, and ready never waits on valid.

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_unused_lsb;
    assign w_unused_lsb = ^{i_araddr[BYTE_AW-1:0], i_awaddr[BYTE_AW-1:0]};

    // ---------------- read channel ----------------
    rd_state_e          r_rd_state, w_rd_state_nxt;
    logic [ID_W-1:0]    r_rid;
    logic [WORD_AW-1:0] r_raddr;
    logic [7:0]         r_rlen;
    logic [7:0]         r_rcnt;
    logic [1:0]         r_rburst;
    logic               r_rerr;
    logic               r_s1_valid;
    logic [DATA_W-1:0]  r_s1_data;
    logic [1:0]         r_s1_resp;
    logic               r_s1_last;

    logic               w_rd_idle;
    logic [WORD_AW-1:0] w_rd_cur;
    logic [7:0]         w_rd_len;
    logic [1:0]         w_rd_burst;
    logic [WORD_AW-1:0] w_rd_next;
    logic               w_rd_err;
    logic               w_ar_hs;
    logic               w_s1_ready;
    logic               w_s1_hs;

    assign w_rd_idle  = (r_rd_state == R_IDLE);
    assign o_arready  = w_rd_idle;
    assign w_ar_hs    = i_arvalid && o_arready;
    assign w_s1_hs    = r_s1_valid && w_s1_ready;

    // In idle the generator sees the incoming AR fields so the error flag is ready at handshake.
    assign w_rd_cur   = w_rd_idle ? i_araddr[ADDR_W-1:BYTE_AW] : r_raddr;
    assign w_rd_len   = w_rd_idle ? i_arlen : r_rlen;
    assign w_rd_burst = w_rd_idle ? i_arburst : r_rburst;

    sram_axi4_addr_gen #(.WORD_AW(WORD_AW)) u_rd_addr_gen (
        .i_addr      (w_rd_cur),
        .i_len       (w_rd_len),
        .i_burst     (w_rd_burst),
        .o_next_addr (w_rd_next),
        .o_burst_err (w_rd_err)
    );

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) r_rd_state <= R_IDLE;
        else          r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_DATA;
            R_DATA:  if (w_s1_hs && r_s1_last) w_rd_state_nxt = R_IDLE;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_rid      <= '0;
            r_raddr    <= '0;
            r_rlen     <= '0;
            r_rcnt     <= '0;
            r_rburst   <= '0;
            r_rerr     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_resp  <= RESP_OKAY;
            r_s1_last  <= 1'b0;
        end else if (w_ar_hs) begin
            r_rid      <= i_arid;
            r_raddr    <= w_rd_cur;
            r_rlen     <= i_arlen;
            r_rcnt     <= '0;
            r_rburst   <= i_arburst;
            r_rerr     <= w_rd_err;
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_rd_err ? '0 : r_mem[w_rd_cur];
            r_s1_resp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            r_s1_last  <= (i_arlen == 8'd0);
        end else if (w_s1_hs) begin
            if (r_s1_last) begin
                r_s1_valid <= 1'b0;
                r_s1_last  <= 1'b0;
            end else begin
                r_raddr   <= w_rd_next;
                r_rcnt    <= r_rcnt + 8'd1;
                r_s1_data <= r_rerr ? '0 : r_mem[w_rd_next];
                r_s1_last <= ((r_rcnt + 8'd1) == r_rlen);
            end
        end
    end

`ifdef SRAM_AXI4_REG_OUT_EN
    logic              r_o_valid;
    logic [DATA_W-1:0] r_o_data;
    logic [1:0]        r_o_resp;
    logic              r_o_last;
    logic [ID_W-1:0]   r_o_rid;

    // The first stage may advance whenever the output slot is empty or draining this cycle.
    assign w_s1_ready = !r_o_valid || i_rready;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_resp  <= RESP_OKAY;
            r_o_last  <= 1'b0;
            r_o_rid   <= '0;
        end else if (w_s1_ready) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_o_data <= r_s1_data;
                r_o_resp <= r_s1_resp;
                r_o_last <= r_s1_last;
                r_o_rid  <= r_rid;
            end else begin
                r_o_last <= 1'b0;
            end
        end
    end

    assign o_rvalid = r_o_valid;
    assign o_rdata  = r_o_data;
    assign o_rresp  = r_o_resp;
    assign o_rlast  = r_o_last;
    assign o_rid    = r_o_rid;
`else
    assign w_s1_ready = i_rready;
    assign o_rvalid   = r_s1_valid;
    assign o_rdata    = r_s1_data;
    assign o_rresp    = r_s1_resp;
    assign o_rlast    = r_s1_last;
    assign o_rid      = r_rid;
`endif

    // ---------------- write channel ----------------
    wr_state_e          r_wr_state, w_wr_state_nxt;
    logic [ID_W-1:0]    r_bid;
    logic [WORD_AW-1:0] r_waddr;
    logic [7:0]         r_wlen;
    logic [7:0]         r_wcnt;
    logic [1:0]         r_wburst;
    logic               r_werr;
    logic               r_wlast_err;
    logic [1:0]         r_bresp;

    logic               w_wr_idle;
    logic [WORD_AW-1:0] w_wr_cur;
    logic [7:0]         w_wr_len;
    logic [1:0]         w_wr_burst;
    logic [WORD_AW-1:0] w_wr_next;
    logic               w_wr_err;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_w_last_beat;
    logic               w_wlast_bad;

    assign w_wr_idle     = (r_wr_state == W_IDLE);
    assign o_awready     = w_wr_idle;
    assign o_wready      = (r_wr_state == W_DATA);
    assign o_bvalid      = (r_wr_state == W_RESP);
    assign o_bid         = r_bid;
    assign o_bresp       = r_bresp;
    assign w_aw_hs       = i_awvalid && o_awready;
    assign w_w_hs        = i_wvalid && o_wready;
    assign w_w_last_beat = (r_wcnt == r_wlen);
    assign w_wlast_bad   = (i_wlast != w_w_last_beat);

    assign w_wr_cur   = w_wr_idle ? i_awaddr[ADDR_W-1:BYTE_AW] : r_waddr;
    assign w_wr_len   = w_wr_idle ? i_awlen : r_wlen;
    assign w_wr_burst = w_wr_idle ? i_awburst : r_wburst;

    sram_axi4_addr_gen #(.WORD_AW(WORD_AW)) u_wr_addr_gen (
        .i_addr      (w_wr_cur),
        .i_len       (w_wr_len),
        .i_burst     (w_wr_burst),
        .o_next_addr (w_wr_next),
        .o_burst_err (w_wr_err)
    );

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) r_wr_state <= W_IDLE;
        else          r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_aw_hs) w_wr_state_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_w_last_beat) w_wr_state_nxt = W_RESP;
            W_RESP:  if (i_bready) w_wr_state_nxt = W_IDLE;
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_bid       <= '0;
            r_waddr     <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wburst    <= '0;
            r_werr      <= 1'b0;
            r_wlast_err <= 1'b0;
            r_bresp     <= RESP_OKAY;
        end else if (w_aw_hs) begin
            r_bid       <= i_awid;
            r_waddr     <= w_wr_cur;
            r_wlen      <= i_awlen;
            r_wcnt      <= '0;
            r_wburst    <= i_awburst;
            r_werr      <= w_wr_err;
            r_wlast_err <= 1'b0;
        end else if (w_w_hs) begin
            r_wlast_err <= r_wlast_err || w_wlast_bad;
            if (w_w_last_beat) begin
                r_bresp <= (r_werr || r_wlast_err || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                r_waddr <= w_wr_next;
                r_wcnt  <= r_wcnt + 8'd1;
            end
        end
    end

    // Storage is never reset; a same-edge read above samples the pre-write word.
    always_ff @(posedge i_aclk) begin
        if (w_w_hs && !r_werr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) r_mem[r_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_axi4_burst.sv
// Directed self-checking bench for sram_axi4_burst (default build, 64-bit data, 12-bit address).
module tb_sram_axi4_burst;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 12;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 512;

    logic                i_aclk = 1'b0;
    logic                i_areset;
    logic [ID_W-1:0]     i_arid;
    logic [ADDR_W-1:0]   i_araddr;
    logic [7:0]          i_arlen;
    logic [1:0]          i_arburst;
    logic                i_arvalid;
    logic                o_arready;
    logic [ID_W-1:0]     o_rid;
    logic [DATA_W-1:0]   o_rdata;
    logic [1:0]          o_rresp;
    logic                o_rlast;
    logic                o_rvalid;
    logic                i_rready;
    logic [ID_W-1:0]     i_awid;
    logic [ADDR_W-1:0]   i_awaddr;
    logic [7:0]          i_awlen;
    logic [1:0]          i_awburst;
    logic                i_awvalid;
    logic                o_awready;
    logic [DATA_W-1:0]   i_wdata;
    logic [STRB_W-1:0]   i_wstrb;
    logic                i_wlast;
    logic                i_wvalid;
    logic                o_wready;
    logic [ID_W-1:0]     o_bid;
    logic [1:0]          o_bresp;
    logic                o_bvalid;
    logic                i_bready;

    always #5 i_aclk = ~i_aclk;

    sram_axi4_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .i_aclk(i_aclk), .i_areset(i_areset),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arburst(i_arburst),
        .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awburst(i_awburst),
        .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready)
    );

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] mem_m [DEPTH];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] wdata_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge; beats come from wdata_q.
    task automatic axi_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [STRB_W-1:0] strb, input int bad_beat,
                             input logic [1:0] exp_resp, input string tag);
        int n;
        int to;
        to = 0;
        i_awid = id; i_awaddr = addr; i_awlen = len; i_awburst = burst; i_awvalid = 1'b1;
        n = 0;
        while (!o_awready && n < 50) begin @(negedge i_aclk); n++; end
        if (n >= 50) to++;
        @(negedge i_aclk);
        i_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            i_wdata  = wdata_q.pop_front();
            i_wstrb  = strb;
            i_wlast  = (b == int'(len)) ^ (b == bad_beat);
            i_wvalid = 1'b1;
            n = 0;
            while (!o_wready && n < 50) begin @(negedge i_aclk); n++; end
            if (n >= 50) to++;
            @(negedge i_aclk);
        end
        i_wvalid = 1'b0; i_wlast = 1'b0; i_bready = 1'b1;
        n = 0;
        while (!o_bvalid && n < 50) begin @(negedge i_aclk); n++; end
        if (n >= 50) to++;
        chk({tag, "_timeouts"}, 64'(to), 64'(0));
        chk({tag, "_bresp"}, 64'(o_bresp), 64'(exp_resp));
        chk({tag, "_bid"}, 64'(o_bid), 64'(id));
        @(negedge i_aclk);
        i_bready = 1'b0;
        chk({tag, "_bvalid_clr"}, 64'(o_bvalid), 64'(0));
    endtask

    // Expected beats come from exp_q; stall_pat[k] is rready on data-phase cycle k (k<4).
    task automatic axi_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] exp_resp, input logic [3:0] stall_pat,
                            input string tag);
        int n;
        int beats;
        logic [DATA_W-1:0] prev;
        logic prev_stall;
        i_arid = id; i_araddr = addr; i_arlen = len; i_arburst = burst; i_arvalid = 1'b1;
        i_rready = 1'b0;
        n = 0;
        while (!o_arready && n < 50) begin @(negedge i_aclk); n++; end
        chk({tag, "_ar_wait"}, 64'(n < 50), 64'(1));
        @(negedge i_aclk);
        i_arvalid = 1'b0;
        chk({tag, "_first_lat"}, 64'(o_rvalid), 64'(1));
        beats = 0; n = 0; prev_stall = 1'b0; prev = '0;
        while (beats <= int'(len) && n < 100) begin
            i_rready = (n < 4) ? stall_pat[n] : 1'b1;
            chk({tag, "_rvalid"}, 64'(o_rvalid), 64'(1));
            if (prev_stall) chk({tag, "_hold"}, o_rdata, prev);
            chk({tag, "_rdata"}, o_rdata, exp_q[0]);
            chk({tag, "_rresp"}, 64'(o_rresp), 64'(exp_resp));
            chk({tag, "_rlast"}, 64'(o_rlast), 64'(beats == int'(len)));
            chk({tag, "_rid"}, 64'(o_rid), 64'(id));
            prev       = o_rdata;
            prev_stall = o_rvalid && !i_rready;
            if (o_rvalid && i_rready) begin
                void'(exp_q.pop_front());
                beats++;
            end
            @(negedge i_aclk);
            n++;
        end
        chk({tag, "_beats"}, 64'(beats), 64'(int'(len) + 1));
        chk({tag, "_rvalid_end"}, 64'(o_rvalid), 64'(0));
        i_rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        i_areset = 1'b1;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arburst = '0; i_arvalid = 1'b0; i_rready = 1'b0;
        i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awburst = '0; i_awvalid = 1'b0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
        repeat (3) @(negedge i_aclk);
        i_areset = 1'b0;
        @(negedge i_aclk);

        // reset values
        chk("rst_arready", 64'(o_arready), 64'(1));
        chk("rst_awready", 64'(o_awready), 64'(1));
        chk("rst_wready",  64'(o_wready),  64'(0));
        chk("rst_rvalid",  64'(o_rvalid),  64'(0));
        chk("rst_rlast",   64'(o_rlast),   64'(0));
        chk("rst_bvalid",  64'(o_bvalid),  64'(0));
        chk("rst_rdata",   o_rdata,        64'(0));
        chk("rst_rid",     64'(o_rid),     64'(0));
        chk("rst_bid",     64'(o_bid),     64'(0));
        chk("rst_rresp",   64'(o_rresp),   64'(0));
        chk("rst_bresp",   64'(o_bresp),   64'(0));

        // preload words 0..15 with one 16-beat INCR burst
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = {32'hDEAD0000 + 32'(i), 32'h0000BEEF};
            wdata_q.push_back(mem_m[i]);
        end
        axi_write(4'h3, 12'h000, 8'd15, 2'b01, 8'hFF, -1, 2'b00, "preload");

        // INCR read from byte 0x08: words 1..4 back to back
        exp_q = {mem_m[1], mem_m[2], mem_m[3], mem_m[4]};
        axi_read(4'h5, 12'h008, 8'd3, 2'b01, 2'b00, 4'b1111, "incr_rd");

        // WRAP write from byte 0x30 lands on words 6,7,4,5
        wdata_q = {64'h0A0A_0000_0000_0006, 64'h0A0A_0000_0000_0007,
                   64'h0A0A_0000_0000_0004, 64'h0A0A_0000_0000_0005};
        axi_write(4'h7, 12'h030, 8'd3, 2'b10, 8'hFF, -1, 2'b00, "wrap_wr");
        mem_m[6] = 64'h0A0A_0000_0000_0006; mem_m[7] = 64'h0A0A_0000_0000_0007;
        mem_m[4] = 64'h0A0A_0000_0000_0004; mem_m[5] = 64'h0A0A_0000_0000_0005;
        exp_q = {mem_m[4], mem_m[5], mem_m[6], mem_m[7]};
        axi_read(4'h1, 12'h020, 8'd3, 2'b01, 2'b00, 4'b1111, "wrap_chk");
        exp_q = {mem_m[7], mem_m[4], mem_m[5], mem_m[6]};
        axi_read(4'h2, 12'h038, 8'd3, 2'b10, 2'b00, 4'b1111, "wrap_rd");

        // byte strobes: low half of a zeroed word 2
        wdata_q = {64'h0};
        axi_write(4'h1, 12'h010, 8'd0, 2'b01, 8'hFF, -1, 2'b00, "zero_w2");
        wdata_q = {64'hFFFF_FFFF_FFFF_FFFF};
        axi_write(4'h1, 12'h010, 8'd0, 2'b01, 8'h0F, -1, 2'b00, "strb_w2");
        mem_m[2] = 64'h0000_0000_FFFF_FFFF;
        exp_q = {64'h0000_0000_FFFF_FFFF};
        axi_read(4'h4, 12'h010, 8'd0, 2'b01, 2'b00, 4'b1111, "strb_rd");

        // illegal bursts: zero data, SLVERR, no memory update
        exp_q = {64'h0, 64'h0, 64'h0, 64'h0};
        axi_read(4'h2, 12'h000, 8'd3, 2'b11, 2'b10, 4'b1111, "rsvd_rd");
        exp_q = {64'h0, 64'h0, 64'h0};
        axi_read(4'h2, 12'h000, 8'd2, 2'b10, 2'b10, 4'b1111, "wrap3_rd");
        wdata_q = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        axi_write(4'h2, 12'h000, 8'd1, 2'b11, 8'hFF, -1, 2'b10, "rsvd_wr");
        wdata_q = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        axi_write(4'h2, 12'h008, 8'd2, 2'b10, 8'hFF, -1, 2'b10, "wrap3_wr");
        exp_q = {mem_m[0], mem_m[1], mem_m[2], mem_m[3]};
        axi_read(4'h3, 12'h000, 8'd3, 2'b01, 2'b00, 4'b1111, "err_unchanged");

        // rready 1-0-0-1 over a 4-beat read of words 8..11
        exp_q = {mem_m[8], mem_m[9], mem_m[10], mem_m[11]};
        axi_read(4'h6, 12'h040, 8'd3, 2'b01, 2'b00, 4'b1001, "stall_rd");

        // wstrb=0 leaves word 3 alone; FIXED read repeats it
        wdata_q = {64'hFFFF_FFFF_FFFF_FFFF};
        axi_write(4'h0, 12'h018, 8'd0, 2'b01, 8'h00, -1, 2'b00, "strb0_wr");
        exp_q = {mem_m[3], mem_m[3], mem_m[3]};
        axi_read(4'h8, 12'h018, 8'd2, 2'b00, 2'b00, 4'b1111, "fixed_rd");

        // wlast early on beat 0, then wlast missing on a single-beat burst
        wdata_q = {64'h1212_1212_1212_1212, 64'h1313_1313_1313_1313};
        axi_write(4'h9, 12'h060, 8'd1, 2'b01, 8'hFF, 0, 2'b10, "wlast_early");
        mem_m[12] = 64'h1212_1212_1212_1212; mem_m[13] = 64'h1313_1313_1313_1313;
        wdata_q = {64'h1414_1414_1414_1414};
        axi_write(4'h9, 12'h070, 8'd0, 2'b01, 8'hFF, 0, 2'b10, "wlast_missing");
        mem_m[14] = 64'h1414_1414_1414_1414;
        exp_q = {mem_m[12], mem_m[13], mem_m[14]};
        axi_read(4'h9, 12'h060, 8'd2, 2'b01, 2'b00, 4'b1111, "wlast_rd");

        // INCR across the top of memory: word 511 then word 0
        wdata_q = {64'h7777_0000_0000_01FF, 64'h7777_0000_0000_0000};
        axi_write(4'hA, 12'hFF8, 8'd1, 2'b01, 8'hFF, -1, 2'b00, "top_wr");
        mem_m[511] = 64'h7777_0000_0000_01FF; mem_m[0] = 64'h7777_0000_0000_0000;
        exp_q = {mem_m[511], mem_m[0]};
        axi_read(4'hA, 12'hFF8, 8'd1, 2'b01, 2'b00, 4'b1111, "top_rd");

        // concurrent read and write bursts on different words
        exp_q = {mem_m[8], mem_m[9]};
        wdata_q = {64'hC0C0_0000_0000_001E, 64'hC0C0_0000_0000_001F};
        fork
            axi_read(4'hB, 12'h040, 8'd1, 2'b01, 2'b00, 4'b1111, "conc_rd");
            axi_write(4'hC, 12'h0F0, 8'd1, 2'b01, 8'hFF, -1, 2'b00, "conc_wr");
        join
        mem_m[30] = 64'hC0C0_0000_0000_001E; mem_m[31] = 64'hC0C0_0000_0000_001F;
        exp_q = {mem_m[30], mem_m[31]};
        axi_read(4'hC, 12'h0F0, 8'd1, 2'b01, 2'b00, 4'b1111, "conc_chk");

        // same-edge AR and W handshake on word 5 returns the old word
        i_awid = 4'h1; i_awaddr = 12'h028; i_awlen = 8'd0; i_awburst = 2'b01; i_awvalid = 1'b1;
        @(negedge i_aclk);
        i_awvalid = 1'b0;
        i_wdata = 64'h5555_5555_5555_5555; i_wstrb = 8'hFF; i_wlast = 1'b1; i_wvalid = 1'b1;
        i_arid = 4'h2; i_araddr = 12'h028; i_arlen = 8'd0; i_arburst = 2'b01; i_arvalid = 1'b1;
        @(negedge i_aclk);
        i_wvalid = 1'b0; i_wlast = 1'b0; i_arvalid = 1'b0;
        chk("rbw_rvalid", 64'(o_rvalid), 64'(1));
        chk("rbw_rdata", o_rdata, mem_m[5]);
        chk("rbw_rlast", 64'(o_rlast), 64'(1));
        chk("rbw_bvalid", 64'(o_bvalid), 64'(1));
        chk("rbw_bresp", 64'(o_bresp), 64'(0));
        i_rready = 1'b1; i_bready = 1'b1;
        @(negedge i_aclk);
        i_rready = 1'b0; i_bready = 1'b0;
        chk("rbw_rvalid_clr", 64'(o_rvalid), 64'(0));
        chk("rbw_bvalid_clr", 64'(o_bvalid), 64'(0));
        mem_m[5] = 64'h5555_5555_5555_5555;
        exp_q = {mem_m[5]};
        axi_read(4'h2, 12'h028, 8'd0, 2'b01, 2'b00, 4'b1111, "rbw_new");

        // reset in the middle of an 8-beat write while a stalled read holds rvalid
        i_awid = 4'hD; i_awaddr = 12'h0A0; i_awlen = 8'd7; i_awburst = 2'b01; i_awvalid = 1'b1;
        i_arid = 4'hD; i_araddr = 12'h040; i_arlen = 8'd7; i_arburst = 2'b01; i_arvalid = 1'b1;
        i_rready = 1'b0;
        @(negedge i_aclk);
        i_awvalid = 1'b0; i_arvalid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            i_wdata = 64'h2020_0000_0000_0000 + 64'(b);
            i_wstrb = 8'hFF; i_wlast = 1'b0; i_wvalid = 1'b1;
            @(negedge i_aclk);
            mem_m[20 + b] = i_wdata;
        end
        chk("mid_rvalid_pre", 64'(o_rvalid), 64'(1));
        i_wvalid = 1'b0;
        i_areset = 1'b1;
        @(negedge i_aclk);
        chk("mid_rst_rvalid", 64'(o_rvalid), 64'(0));
        chk("mid_rst_bvalid", 64'(o_bvalid), 64'(0));
        chk("mid_rst_awready", 64'(o_awready), 64'(1));
        chk("mid_rst_arready", 64'(o_arready), 64'(1));
        chk("mid_rst_wready", 64'(o_wready), 64'(0));
        chk("mid_rst_rdata", o_rdata, 64'(0));
        i_areset = 1'b0;
        @(negedge i_aclk);
        wdata_q = {64'h3030_0000_0000_0014, 64'h3030_0000_0000_0015};
        axi_write(4'hE, 12'h0A0, 8'd1, 2'b01, 8'hFF, -1, 2'b00, "post_rst_wr");
        mem_m[20] = 64'h3030_0000_0000_0014; mem_m[21] = 64'h3030_0000_0000_0015;
        exp_q = {mem_m[20], mem_m[21], mem_m[22]};
        axi_read(4'hE, 12'h0A0, 8'd2, 2'b01, 2'b00, 4'b1111, "post_rst_rd");
        exp_q = {mem_m[1]};
        axi_read(4'h1, 12'h008, 8'd0, 2'b01, 2'b00, 4'b1111, "mem_kept");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
